// File: rtl/vx_tex_sat_pipe.sv
// rtl/vx_tex_sat_pipe.sv - two-stage elastic round/shift + saturating clamp pipeline
// Optional statistics counters are enabled by defining VX_TEX_SAT_STATS_EN.
module vx_tex_sat_pipe #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 24,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0,
    parameter int TAG_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [NUM_CH*IN_W-1:0]  data_in,
    input  logic                    signed_in,
    input  logic [TAG_W-1:0]        tag_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [NUM_CH*OUT_W-1:0] data_out,
    output logic [TAG_W-1:0]        tag_out,
    output logic [NUM_CH-1:0]       ovf_out,
    output logic [NUM_CH-1:0]       unf_out,
    input  logic                    clear_stats,
    output logic [31:0]             ovf_count,
    output logic [31:0]             unf_count
);

    generate
        if (!(IN_W > OUT_W + SHIFT + 1) || NUM_CH < 1) begin : g_bad_cfg
            $error("vx_tex_sat_pipe: illegal parameter combination");
        end
    endgenerate

    // One extra bit holds the rounding add without wrap; the shifted result keeps that width.
    localparam int SW = IN_W + 1;
    localparam logic signed [SW-1:0] RND_BIAS = SW'((64'd1 << SHIFT) >> 1);
    localparam logic signed [SW-1:0] U_MAX = {{(SW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic signed [SW-1:0] S_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                   s1_valid;
    logic signed [SW-1:0]   s1_val [NUM_CH];
    logic                   s1_signed;
    logic [TAG_W-1:0]       s1_tag;
    logic signed [SW-1:0]   rnd_val [NUM_CH];
    logic [OUT_W-1:0]       clamp_val [NUM_CH];
    logic [NUM_CH-1:0]      clamp_ovf;
    logic [NUM_CH-1:0]      clamp_unf;
    logic                   s2_adv;

    assign s2_adv   = !valid_out || ready_out;
    assign ready_in = !s1_valid || s2_adv;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            rnd_val[i] = ($signed({data_in[i*IN_W+IN_W-1], data_in[i*IN_W +: IN_W]}) + RND_BIAS) >>> SHIFT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_signed <= 1'b0;
            s1_tag    <= '0;
            for (int i = 0; i < NUM_CH; i++) s1_val[i] <= '0;
        end else if (ready_in) begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_signed <= signed_in;
                s1_tag    <= tag_in;
                for (int i = 0; i < NUM_CH; i++) s1_val[i] <= rnd_val[i];
            end
        end
    end

    always_comb begin
        clamp_ovf = '0;
        clamp_unf = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            clamp_val[i] = s1_val[i][OUT_W-1:0];
            if (s1_signed) begin
                if (s1_val[i] < S_MIN) begin
                    clamp_val[i] = {1'b1, {(OUT_W-1){1'b0}}};
                    clamp_unf[i] = 1'b1;
                end else if (s1_val[i] > S_MAX) begin
                    clamp_val[i] = {1'b0, {(OUT_W-1){1'b1}}};
                    clamp_ovf[i] = 1'b1;
                end
            end else begin
                if (s1_val[i][SW-1]) begin
                    clamp_val[i] = '0;
                    clamp_unf[i] = 1'b1;
                end else if (s1_val[i] > U_MAX) begin
                    clamp_val[i] = '1;
                    clamp_ovf[i] = 1'b1;
                end
            end
        end
    end

    // Output registers only load when the stage advances, so a stalled beat holds steady.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            tag_out   <= '0;
            ovf_out   <= '0;
            unf_out   <= '0;
        end else if (s2_adv) begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                tag_out <= s1_tag;
                ovf_out <= clamp_ovf;
                unf_out <= clamp_unf;
                for (int i = 0; i < NUM_CH; i++) data_out[i*OUT_W +: OUT_W] <= clamp_val[i];
            end
        end
    end

`ifdef VX_TEX_SAT_STATS_EN
    logic out_fire;
    assign out_fire = valid_out && ready_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else if (clear_stats) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else begin
            if (out_fire && (|ovf_out) && (ovf_count != 32'hFFFF_FFFF)) ovf_count <= ovf_count + 32'd1;
            if (out_fire && (|unf_out) && (unf_count != 32'hFFFF_FFFF)) unf_count <= unf_count + 32'd1;
        end
    end
`else
    logic unused_clear_stats;
    assign unused_clear_stats = clear_stats;
    assign ovf_count = '0;
    assign unf_count = '0;
`endif

endmodule

// File: tb/tb_vx_tex_sat_pipe.sv
// tb/tb_vx_tex_sat_pipe.sv - self-checking bench for vx_tex_sat_pipe
module tb_vx_tex_sat_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        valid_in, ready_in, signed_in, valid_out, ready_out, clear_stats;
    logic [95:0] data_in;
    logic [3:0]  tag_in, tag_out, ovf_out, unf_out;
    logic [31:0] data_out, ovf_count, unf_count;

    logic        v4_in, r4_in, s4_in, v4_out, r4_out;
    logic [95:0] d4_in;
    logic [3:0]  t4_in, t4_out, o4_out, u4_out;
    logic [31:0] d4_out, oc4, uc4;

    vx_tex_sat_pipe #(.NUM_CH(4), .IN_W(24), .OUT_W(8), .SHIFT(0), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .data_in(data_in), .signed_in(signed_in), .tag_in(tag_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .tag_out(tag_out), .ovf_out(ovf_out), .unf_out(unf_out),
        .clear_stats(clear_stats), .ovf_count(ovf_count), .unf_count(unf_count));

    vx_tex_sat_pipe #(.NUM_CH(4), .IN_W(24), .OUT_W(8), .SHIFT(4), .TAG_W(4)) dut4 (
        .clk(clk), .reset(reset), .valid_in(v4_in), .ready_in(r4_in),
        .data_in(d4_in), .signed_in(s4_in), .tag_in(t4_in),
        .valid_out(v4_out), .ready_out(r4_out), .data_out(d4_out),
        .tag_out(t4_out), .ovf_out(o4_out), .unf_out(u4_out),
        .clear_stats(clear_stats), .ovf_count(oc4), .unf_count(uc4));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: floor((v + 2^(sh-1)) / 2^sh), then clamp; returns {ovf, unf, out[7:0]}.
    function automatic logic [9:0] sat1(input int v, input bit sgn, input int sh);
        longint d, s, q, lo, hi;
        d = longint'(1) << sh;
        s = longint'(v) + d / 2;
        q = s / d;
        if (s < 0 && (s % d) != 0) q = q - 1;
        lo = sgn ? -128 : 0;
        hi = sgn ? 127 : 255;
        if (q < lo) return {2'b01, lo[7:0]};
        if (q > hi) return {2'b10, hi[7:0]};
        return {2'b00, q[7:0]};
    endfunction

    // Packet layout {tag, unf, ovf, data}.
    function automatic logic [43:0] pkt(input logic [95:0] d, input bit sgn, input int sh, input logic [3:0] tag);
        logic [31:0] o;
        logic [3:0]  ov, un;
        logic [9:0]  r;
        for (int i = 0; i < 4; i++) begin
            r = sat1(int'($signed(d[i*24 +: 24])), sgn, sh);
            o[i*8 +: 8] = r[7:0];
            ov[i] = r[9];
            un[i] = r[8];
        end
        return {tag, un, ov, o};
    endfunction

    function automatic logic [95:0] ch4(input int a, input int b, input int c, input int e);
        return {e[23:0], c[23:0], b[23:0], a[23:0]};
    endfunction

    function automatic logic [95:0] rnd_data();
        logic [95:0] d;
        int v;
        for (int i = 0; i < 4; i++) begin
            v = int'($urandom_range(0, 1023)) - 512;
            d[i*24 +: 24] = ($urandom_range(0, 7) == 0) ? 24'($urandom) : v[23:0];
        end
        return d;
    endfunction

    task automatic run0(input logic [95:0] d, input bit sgn, input logic [3:0] tag, output logic [43:0] obs);
        @(negedge clk);
        valid_in = 1'b1; data_in = d; signed_in = sgn; tag_in = tag; ready_out = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        chk("lat_not_early", valid_out, 1'b0);
        @(negedge clk);
        chk("lat_valid", valid_out, 1'b1);
        obs = {tag_out, unf_out, ovf_out, data_out};
    endtask

    task automatic run4(input logic [95:0] d, input bit sgn, input logic [3:0] tag, output logic [43:0] obs);
        @(negedge clk);
        v4_in = 1'b1; d4_in = d; s4_in = sgn; t4_in = tag;
        @(posedge clk); #1;
        v4_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lat4_valid", v4_out, 1'b1);
        obs = {t4_out, u4_out, o4_out, d4_out};
    endtask

    logic [43:0] obs, held, e;
    logic [43:0] q[$];
    logic [95:0] d;
    logic        sg;
    logic        stall, clr_pending;
    int          sent, got, nout;

    initial begin
        reset = 1'b1; valid_in = 0; ready_out = 0; signed_in = 0; data_in = '0; tag_in = '0;
        clear_stats = 0; v4_in = 0; r4_out = 1'b1; s4_in = 0; d4_in = '0; t4_in = '0;
        #1;
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_ready_in", ready_in, 1'b1);
        chk("rst_outputs", {tag_out, unf_out, ovf_out, data_out}, 44'h0);
        chk("rst_counts", {ovf_count, unf_count}, 64'h0);
        #20;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready_in", ready_in, 1'b1);

        run0(ch4(-5, 0, 200, 300), 1'b0, 4'h3, obs);
        chk("unsigned_clamp", obs, {4'h3, 4'b0001, 4'b1000, 32'hFFC8_0000});
        run0(ch4(-129, -128, 127, 128), 1'b1, 4'h5, obs);
        chk("signed_clamp", obs, {4'h5, 4'b0001, 4'b1000, 32'h7F7F_8080});
        run4(ch4(24, 23, 4088, 4096), 1'b0, 4'h9, obs);
        chk("shift4_round", obs, {4'h9, 4'b0000, 4'b1100, 32'hFFFF_0102});

        for (int k = 0; k < 6; k++) begin
            d = rnd_data(); sg = 1'($urandom_range(0, 1));
            run0(d, sg, 4'(k), obs);
            chk("rand_sh0", obs, pkt(d, sg, 0, 4'(k)));
            d = rnd_data(); sg = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) d[i*24 +: 24] = 24'(int'($urandom_range(0, 16383)) - 8192);
            run4(d, sg, 4'(k), obs);
            chk("rand_sh4", obs, pkt(d, sg, 4, 4'(k)));
        end

        // Streaming with random back-pressure, scoreboarded in order.
        sent = 0; got = 0; stall = 0; held = '0;
        for (int c = 0; c < 400 && got < 10; c++) begin
            @(negedge clk);
            if (stall) chk("stall_hold", {tag_out, unf_out, ovf_out, data_out}, held);
            ready_out = 1'($urandom_range(0, 1));
            if (sent < 10 && $urandom_range(0, 3) != 0) begin
                valid_in = 1'b1; data_in = rnd_data(); signed_in = 1'($urandom_range(0, 1)); tag_in = 4'(sent);
            end else begin
                valid_in = 1'b0;
            end
            #1;
            chk("ready_in_rule", ready_in, !(q.size() == 2 && !ready_out));
            if (valid_out && ready_out) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("stream_pkt", {tag_out, unf_out, ovf_out, data_out}, e);
                    got++;
                end
            end
            if (valid_in && ready_in) begin
                q.push_back(pkt(data_in, signed_in, 0, tag_in));
                sent++;
            end
            stall = valid_out && !ready_out;
            held = {tag_out, unf_out, ovf_out, data_out};
        end
        chk("stream_count", 64'(got), 64'd10);
        @(negedge clk);
        valid_in = 1'b0; ready_out = 1'b1;
        repeat (3) @(negedge clk);

        // Reset with two transactions in flight.
        ready_out = 1'b0; valid_in = 1'b1; data_in = ch4(1, 2, 3, 4); signed_in = 0;
        @(negedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        chk("full_valid_out", valid_out, 1'b1);
        chk("full_ready_in", ready_in, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid_out", valid_out, 1'b0);
        chk("midrst_ready_in", ready_in, 1'b1);
        chk("midrst_data", data_out, 32'h0);
        @(negedge clk);
        reset = 1'b0; ready_out = 1'b1;
        nout = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (valid_out) nout++;
        end
        chk("midrst_no_output", 64'(nout), 64'd0);

        // Overflow counter with clear coinciding with the 4th counted transfer.
        nout = 0; clr_pending = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (clr_pending) begin
`ifdef VX_TEX_SAT_STATS_EN
                chk("ovf_cnt_after_clear", ovf_count, 32'd0);
`else
                chk("ovf_cnt_tied", ovf_count, 32'd0);
`endif
                clr_pending = 0;
            end
            clear_stats = 1'b0;
            valid_in = (c < 4); data_in = ch4(300, 300, 300, 300); signed_in = 0;
            #1;
            if (valid_out && ready_out) begin
                nout++;
                if (nout == 4) begin
`ifdef VX_TEX_SAT_STATS_EN
                    chk("ovf_cnt_before_clear", ovf_count, 32'd3);
`else
                    chk("ovf_cnt_tied", ovf_count, 32'd0);
`endif
                    clear_stats = 1'b1;
                    clr_pending = 1'b1;
                end
            end
        end
        chk("stats_outputs", 64'(nout), 64'd4);
        chk("unf_cnt", unf_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
